// File: rtl/beam_metadata_builder.sv
// Encodes a 48-bit beam trigger vector into an 8-bit region byte captured on trig_i.
// One-cycle latency (trig_o/meta_o follow trig_i by one clock); no backpressure.
module beam_metadata_builder (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        trig_i,
  input  logic [47:0] beam_i,
  output logic [7:0]  meta_o,
  output logic        trig_o
);

  // Beams on a 7-wide grid; the upper nibble selects one of four
  // row/column quadrants: sel 3=CL/RA, 2=CH/RA, 1=CL/RB, 0=CH/RB.
  function automatic logic [47:0] quad_mask(input int sel);
    logic [47:0] m;
    int          row;
    int          col;
    int          grp;
    m = '0;
    for (int b = 0; b < 48; b++) begin
      row = b / 7;
      col = b % 7;
      grp = 0;
      if (row == 0 || row == 1 || row == 2 || row == 5) grp += 2;
      if (col < 3) grp += 1;
      m[b] = (grp == sel);
    end
    return m;
  endfunction

  function automatic logic [47:0] mod4_mask(input int k);
    logic [47:0] m;
    m = '0;
    for (int b = 0; b < 48; b++) m[b] = ((b % 4) == k);
    return m;
  endfunction

  localparam logic [47:0] MASK_B7 = quad_mask(3);
  localparam logic [47:0] MASK_B6 = quad_mask(2);
  localparam logic [47:0] MASK_B5 = quad_mask(1);
  localparam logic [47:0] MASK_B4 = quad_mask(0);
  localparam logic [47:0] MASK_B3 = mod4_mask(3);
  localparam logic [47:0] MASK_B2 = mod4_mask(2);
  localparam logic [47:0] MASK_B1 = mod4_mask(1);
  localparam logic [47:0] MASK_B0 = mod4_mask(0);

  logic [7:0] meta_nxt;

  always_comb begin
    meta_nxt    = '0;
    meta_nxt[7] = |(beam_i & MASK_B7);
    meta_nxt[6] = |(beam_i & MASK_B6);
    meta_nxt[5] = |(beam_i & MASK_B5);
    meta_nxt[4] = |(beam_i & MASK_B4);
    meta_nxt[3] = |(beam_i & MASK_B3);
    meta_nxt[2] = |(beam_i & MASK_B2);
    meta_nxt[1] = |(beam_i & MASK_B1);
    meta_nxt[0] = |(beam_i & MASK_B0);
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      meta_o <= '0;
      trig_o <= 1'b0;
    end else begin
      trig_o <= trig_i;
      if (trig_i) meta_o <= meta_nxt;
    end
  end

endmodule

// File: tb/tb_beam_metadata_builder.sv
// Scoreboarded bench for beam_metadata_builder: expected {trig_o, meta_o} queued per
// driven cycle and compared one clock later.
module tb_beam_metadata_builder;

  logic        clk_i;
  logic        aresetn_i;
  logic        trig_i;
  logic [47:0] beam_i;
  logic [7:0]  meta_o;
  logic        trig_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       trig;
    logic [7:0] meta;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_meta;

  beam_metadata_builder dut (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .trig_i    (trig_i),
    .beam_i    (beam_i),
    .meta_o    (meta_o),
    .trig_o    (trig_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Reference encoder written from the row/column grouping tables.
  function automatic logic [7:0] ref_meta(input logic [47:0] v);
    logic [7:0] m;
    int         row;
    int         col;
    logic       in_ra;
    logic       in_cl;
    m = 8'h00;
    for (int b = 0; b < 48; b++) begin
      if (v[b]) begin
        row = b / 7;
        col = b % 7;
        case (row)
          0, 1, 2, 5: in_ra = 1'b1;
          default:    in_ra = 1'b0;
        endcase
        in_cl = (col <= 2);
        if (in_cl && in_ra)        m = m | 8'h80;
        else if (!in_cl && in_ra)  m = m | 8'h40;
        else if (in_cl && !in_ra)  m = m | 8'h20;
        else                       m = m | 8'h10;
        case (b % 4)
          0:       m = m | 8'h01;
          1:       m = m | 8'h02;
          2:       m = m | 8'h04;
          default: m = m | 8'h08;
        endcase
      end
    end
    return m;
  endfunction

  // Drive one cycle, queue the expectation, then compare after the edge.
  task automatic step(input logic trig, input logic [47:0] beam, input string tag);
    exp_t e;
    exp_t got_e;
    trig_i = trig;
    beam_i = beam;
    if (trig) model_meta = ref_meta(beam);
    e.trig = trig;
    e.meta = model_meta;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      got_e = sb_q.pop_front();
      check({tag, "_meta"}, meta_o, got_e.meta);
      check({tag, "_trig"}, {7'd0, trig_o}, {7'd0, got_e.trig});
    end
  endtask

  function automatic logic [47:0] one_beam(input int b);
    logic [47:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    int          grp[12] = '{0, 1, 2, 7, 8, 9, 14, 15, 16, 35, 36, 37};
    logic [63:0] rnd;

    model_meta = 8'h00;
    aresetn_i  = 1'b0;
    trig_i     = 1'b1;
    beam_i     = '1;

    // Reset held with active trigger: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check("rst_meta", meta_o, 8'h00);
      check("rst_trig", {7'd0, trig_o}, 8'h00);
    end
    trig_i = 1'b0;
    beam_i = '0;
    #3 aresetn_i = 1'b1;
    @(posedge clk_i);
    #1;

    step(1'b1, one_beam(7), "beam7");
    check("beam7_const", meta_o, 8'h88);
    step(1'b0, '0, "beam7_hold");
    check("beam7_hold_const", meta_o, 8'h88);
    step(1'b1, one_beam(12), "beam12");
    check("beam12_const", meta_o, 8'h41);
    step(1'b0, '0, "beam12_hold");

    foreach (grp[i]) begin
      step(1'b1, one_beam(grp[i]), $sformatf("grp_b%0d", grp[i]));
      check($sformatf("grp_b%0d_hi", grp[i]), {4'd0, meta_o[7:4]}, 8'h08);
      if (grp[i] == 0)  check("beam0_const", meta_o, 8'h81);
      if (grp[i] == 37) check("beam37_const", meta_o, 8'h82);
    end

    step(1'b1, one_beam(0) | one_beam(47), "b0_b47");
    check("b0_b47_const", meta_o, 8'h99);
    step(1'b0, '1, "gated_ones");
    check("gated_const", meta_o, 8'h99);
    step(1'b1, '0, "zero_trig");
    check("zero_trig_const", meta_o, 8'h00);

    // Back-to-back triggers: no merging, trig_o high for both cycles.
    step(1'b1, one_beam(7), "b2b_first");
    check("b2b_first_const", meta_o, 8'h88);
    step(1'b1, one_beam(12), "b2b_second");
    check("b2b_second_const", meta_o, 8'h41);
    step(1'b0, '0, "b2b_end");

    // Every single beam.
    for (int b = 0; b < 48; b++) step(1'b1, one_beam(b), $sformatf("single_b%0d", b));

    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), rnd[47:0], "rand");
    end

    // Mid-operation reset clears outputs without waiting for a clock edge.
    step(1'b1, one_beam(47), "pre_rst");
    trig_i = 1'b1;
    beam_i = '1;
    #2 aresetn_i = 1'b0;
    #1;
    check("midrst_meta", meta_o, 8'h00);
    check("midrst_trig", {7'd0, trig_o}, 8'h00);
    @(posedge clk_i);
    #1;
    check("midrst_hold_meta", meta_o, 8'h00);
    trig_i = 1'b0;
    #2 aresetn_i = 1'b1;
    model_meta = 8'h00;
    @(posedge clk_i);
    #1;
    check("post_rst_meta", meta_o, 8'h00);
    step(1'b1, one_beam(12), "post_rst_b12");
    check("post_rst_b12_const", meta_o, 8'h41);
    step(1'b0, '0, "post_rst_idle");

    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
